// File: rtl/dmni_mem_arbiter.sv
// dmni_mem_arbiter: shares one scratchpad port between CPU and DMNI DMA with a DMA burst quota.
module dmni_mem_arbiter #(
  parameter int DMA_QUOTA = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic [3:0]  cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic        cpu_gnt_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_data_o,
  input  logic        dma_req_i,
  input  logic [3:0]  dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_data_i,
  output logic        dma_gnt_o,
  output logic        dma_rvalid_o,
  output logic [31:0] dma_data_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);
  localparam int CW = $clog2(DMA_QUOTA + 1);
  localparam logic [CW-1:0] QUOTA = CW'(DMA_QUOTA);
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;
  logic [CW-1:0] run_cnt_q, run_cnt_d;
  owner_e rd_owner_q, rd_owner_d;
  logic dma_win;
  always_comb begin
    dma_win = dma_req_i & (~cpu_req_i | (run_cnt_q < QUOTA));
    dma_gnt_o = ~rst_i & dma_win;
    cpu_gnt_o = ~rst_i & cpu_req_i & ~dma_win;
    mem_en_o = cpu_gnt_o | dma_gnt_o;
    mem_we_o = cpu_gnt_o ? cpu_we_i : dma_gnt_o ? dma_we_i : '0;
    mem_addr_o = cpu_gnt_o ? cpu_addr_i : dma_gnt_o ? dma_addr_i : '0;
    mem_data_o = cpu_gnt_o ? cpu_data_i : dma_gnt_o ? dma_data_i : '0;
    run_cnt_d = (dma_gnt_o & cpu_req_i) ? ((run_cnt_q == QUOTA) ? QUOTA : run_cnt_q + 1'b1) : '0;
    rd_owner_d = (cpu_gnt_o && cpu_we_i == '0) ? OWN_CPU : (dma_gnt_o && dma_we_i == '0) ? OWN_DMA : OWN_NONE;
    // a read in flight when reset hits is dropped; the requester re-issues
    cpu_rvalid_o = ~rst_i & (rd_owner_q == OWN_CPU);
    dma_rvalid_o = ~rst_i & (rd_owner_q == OWN_DMA);
    cpu_data_o = mem_data_i;
    dma_data_o = mem_data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_cnt_q <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      run_cnt_q <= run_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end
endmodule

// File: tb/tb_dmni_mem_arbiter.sv
// tb_dmni_mem_arbiter: directed and randomized checks of the CPU/DMA memory arbiter against a reference model.
module tb_dmni_mem_arbiter;
  localparam int Q = 8;
  logic clk = 0;
  logic rst_i = 1;
  logic cpu_req_i = 0, dma_req_i = 0;
  logic [3:0] cpu_we_i = 0, dma_we_i = 0;
  logic [31:0] cpu_addr_i = 0, cpu_data_i = 0, dma_addr_i = 0, dma_data_i = 0;
  logic cpu_gnt_o, cpu_rvalid_o, dma_gnt_o, dma_rvalid_o, mem_en_o;
  logic [31:0] cpu_data_o, dma_data_o, mem_addr_o, mem_data_o, mem_data_i;
  logic [3:0] mem_we_o;
  int checks = 0, failures = 0;

  dmni_mem_arbiter #(.DMA_QUOTA(Q)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_data_o(cpu_data_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i), .dma_data_i(dma_data_i),
    .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o), .dma_data_o(dma_data_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  // scratchpad with one cycle read latency, driven only by the DUT's memory port
  logic [31:0] mem [256];
  logic [31:0] mem_rdata = 0;
  assign mem_data_i = mem_rdata;
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o == 4'h0) mem_rdata <= mem[mem_addr_o[9:2]];
      else for (int b = 0; b < 4; b++) if (mem_we_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
    end
  end

  // reference model: owner of each cycle from the arbitration rules, plus expected memory contents
  logic [31:0] ref_mem [256];
  int streak = 0;
  int pend = 0;
  logic [31:0] pend_data = 0;
  int eg;
  bit ecv, edv;
  logic [31:0] erd, e_addr, e_data;
  logic [3:0] e_we;

  function automatic int pick(bit c, bit d);
    return (c && d) ? ((streak < Q) ? 2 : 1) : c ? 1 : d ? 2 : 0;
  endfunction

  task automatic cyc(input bit r, input bit c, input logic [3:0] cwe, input logic [31:0] ca, input logic [31:0] cd,
                     input bit d, input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk); #1;
    rst_i = r; cpu_req_i = c; cpu_we_i = cwe; cpu_addr_i = ca; cpu_data_i = cd;
    dma_req_i = d; dma_we_i = dwe; dma_addr_i = da; dma_data_i = dd;
    @(negedge clk);
    ecv = !r && pend == 1;
    edv = !r && pend == 2;
    erd = pend_data;
    eg = r ? 0 : pick(c, d);
    e_we = eg == 1 ? cwe : eg == 2 ? dwe : 4'h0;
    e_addr = eg == 1 ? ca : eg == 2 ? da : 32'h0;
    e_data = eg == 1 ? cd : eg == 2 ? dd : 32'h0;
    pend = 0;
    if (r) streak = 0;
    else begin
      streak = (eg == 2 && c) ? ((streak < Q) ? streak + 1 : Q) : 0;
      if (eg != 0) begin
        if (e_we == 4'h0) begin pend = eg; pend_data = ref_mem[e_addr[9:2]]; end
        else for (int b = 0; b < 4; b++) if (e_we[b]) ref_mem[e_addr[9:2]][8*b +: 8] = e_data[8*b +: 8];
      end
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 32'h8, 0, 1, 0, 32'hC, 0);
      checks++; if ({cpu_gnt_o, dma_gnt_o} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b want=00", {cpu_gnt_o, dma_gnt_o}); end
      checks++; if ({mem_en_o, mem_we_o} !== 5'b0) begin failures++; $display("FAIL reset_mem got en=%b we=%h want 0", mem_en_o, mem_we_o); end
      checks++; if ({cpu_rvalid_o, dma_rvalid_o} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b want=00", {cpu_rvalid_o, dma_rvalid_o}); end
    end
    cyc(0, 1, 0, 32'h8, 0, 1, 0, 32'hC, 0);
    checks++; if ({cpu_gnt_o, dma_gnt_o} !== 2'b01) begin failures++; $display("FAIL reset_first_gnt got=%b want=01", {cpu_gnt_o, dma_gnt_o}); end
    checks++; if ({cpu_rvalid_o, dma_rvalid_o} !== 2'b00) begin failures++; $display("FAIL reset_release_rvalid got=%b want=00", {cpu_rvalid_o, dma_rvalid_o}); end
    cyc(0, 1, 0, 32'h8, 0, 0, 0, 0, 0);
    checks++; if ({cpu_gnt_o, dma_rvalid_o, dma_data_o} !== {2'b11, ref_mem[3]}) begin failures++; $display("FAIL reset_dma_read got gnt=%b rv=%b d=%h want 1 1 %h", cpu_gnt_o, dma_rvalid_o, dma_data_o, ref_mem[3]); end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (cpu_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_drop_rvalid got=%b want=0", cpu_rvalid_o); end
    idle();
    checks++; if ({cpu_rvalid_o, dma_rvalid_o} !== 2'b00) begin failures++; $display("FAIL reset_after_rvalid got=%b want=00", {cpu_rvalid_o, dma_rvalid_o}); end
  endtask

  task automatic test_solo_cpu();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) cyc(0, 1, 0, 32'h100, 0, 0, 0, 0, 0); else idle();
      if (i < 4) begin
        checks++; if ({cpu_gnt_o, dma_gnt_o, mem_addr_o} !== {2'b10, 32'h100}) begin failures++; $display("FAIL solo_gnt c%0d got=%b addr=%h want 10 100", i, {cpu_gnt_o, dma_gnt_o}, mem_addr_o); end
      end
      checks++; if (cpu_rvalid_o !== (i > 0)) begin failures++; $display("FAIL solo_rvalid c%0d got=%b want=%b", i, cpu_rvalid_o, i > 0); end
      if (i > 0) begin
        checks++; if (cpu_data_o !== ref_mem[32'h100 >> 2]) begin failures++; $display("FAIL solo_data c%0d got=%h want=%h", i, cpu_data_o, ref_mem[32'h100 >> 2]); end
      end
      checks++; if (dma_rvalid_o !== 1'b0) begin failures++; $display("FAIL solo_dma_rvalid c%0d got=%b want=0", i, dma_rvalid_o); end
    end
  endtask

  task automatic test_contention();
    idle();
    for (int i = 0; i < 27; i++) begin
      cyc(0, 1, 0, 32'h200, 0, 1, 0, 32'h300, 0);
      checks++;
      if ({cpu_gnt_o, dma_gnt_o, mem_en_o} !== ((i % 9 == 8) ? 3'b101 : 3'b011)) begin
        failures++; $display("FAIL contention c%0d got gnt=%b en=%b want cpu=%0d", i, {cpu_gnt_o, dma_gnt_o}, mem_en_o, i % 9 == 8);
      end
    end
  endtask

  task automatic test_interleave();
    idle();
    cyc(0, 1, 0, 32'h10, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'h20, 0);
    checks++; if ({cpu_rvalid_o, dma_rvalid_o, cpu_data_o} !== {2'b10, ref_mem[4]}) begin failures++; $display("FAIL interleave_cpu got rv=%b d=%h want 10 %h", {cpu_rvalid_o, dma_rvalid_o}, cpu_data_o, ref_mem[4]); end
    idle();
    checks++; if ({cpu_rvalid_o, dma_rvalid_o, dma_data_o} !== {2'b01, ref_mem[8]}) begin failures++; $display("FAIL interleave_dma got rv=%b d=%h want 01 %h", {cpu_rvalid_o, dma_rvalid_o}, dma_data_o, ref_mem[8]); end
  endtask

  task automatic test_write();
    idle();
    cyc(0, 0, 0, 0, 0, 1, 4'hF, 32'h40, 32'hDEADBEEF);
    checks++; if ({dma_gnt_o, mem_we_o, mem_addr_o, mem_data_o} !== {1'b1, 4'hF, 32'h40, 32'hDEADBEEF}) begin failures++; $display("FAIL write_mux got g=%b we=%h a=%h d=%h", dma_gnt_o, mem_we_o, mem_addr_o, mem_data_o); end
    cyc(0, 1, 0, 32'h40, 0, 0, 0, 0, 0);
    checks++; if ({cpu_rvalid_o, dma_rvalid_o} !== 2'b00) begin failures++; $display("FAIL write_no_rvalid got=%b want=00", {cpu_rvalid_o, dma_rvalid_o}); end
    idle();
    checks++; if ({cpu_rvalid_o, cpu_data_o} !== {1'b1, 32'hDEADBEEF}) begin failures++; $display("FAIL write_readback got rv=%b d=%h want 1 deadbeef", cpu_rvalid_o, cpu_data_o); end
  endtask

  task automatic test_counter_reset();
    idle();
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
      checks++; if (dma_gnt_o !== 1'b1) begin failures++; $display("FAIL cnt_pre c%0d got=%b want=1", i, dma_gnt_o); end
    end
    cyc(0, 0, 0, 0, 0, 1, 0, 32'h8, 0);
    checks++; if (dma_gnt_o !== 1'b1) begin failures++; $display("FAIL cnt_drop got=%b want=1", dma_gnt_o); end
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
      checks++; if ({cpu_gnt_o, dma_gnt_o} !== ((i == 8) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL cnt_restart c%0d got=%b want cpu=%0d", i, {cpu_gnt_o, dma_gnt_o}, i == 8); end
    end
  endtask

  task automatic test_random();
    bit ch = 0, dh = 0;
    logic [3:0] cw = 0, dw = 0;
    logic [31:0] ca = 0, cd = 0, da = 0, dd = 0;
    idle();
    for (int i = 0; i < 400; i++) begin
      if (!ch && $urandom_range(0, 9) < 7) begin
        ch = 1; cw = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)); ca = {22'h0, 8'($urandom), 2'b00}; cd = $urandom;
      end
      if (!dh && $urandom_range(0, 9) < 8) begin
        dh = 1; dw = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15)); da = {22'h0, 8'($urandom), 2'b00}; dd = $urandom;
      end
      cyc(0, ch, cw, ca, cd, dh, dw, da, dd);
      checks++;
      if ({cpu_gnt_o, dma_gnt_o} !== {eg == 1, eg == 2} || mem_en_o !== (eg != 0) || mem_we_o !== e_we || mem_addr_o !== e_addr || mem_data_o !== e_data) begin
        failures++; $display("FAIL rand_grant c%0d got g=%b en=%b we=%h a=%h d=%h want owner=%0d we=%h a=%h d=%h", i, {cpu_gnt_o, dma_gnt_o}, mem_en_o, mem_we_o, mem_addr_o, mem_data_o, eg, e_we, e_addr, e_data);
      end
      checks++;
      if (cpu_rvalid_o !== ecv || dma_rvalid_o !== edv || (ecv && cpu_data_o !== erd) || (edv && dma_data_o !== erd)) begin
        failures++; $display("FAIL rand_read c%0d got rv=%b cd=%h dd=%h want rv=%b%b d=%h", i, {cpu_rvalid_o, dma_rvalid_o}, cpu_data_o, dma_data_o, ecv, edv, erd);
      end
      if (eg == 1) ch = 0;
      if (eg == 2) dh = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    test_reset();
    test_solo_cpu();
    test_contention();
    test_interleave();
    test_write();
    test_counter_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
